sram_mem_ctrl: RTL and testbench
================================

# sram_mem_ctrl

Multi-cycle controller sequencing the MEM stage's 32-bit data accesses onto an external 16-bit asynchronous SRAM. It consumes the memory-enable, address and store-value outputs of the EX/MEM pipeline register, splits each word access into two half-word SRAM cycles, and holds `ready` low until the access completes so the pipeline freezes. It sits between the EX/MEM register and the MEM/WB register, and is the only master of the SRAM pins.

## Interface
- `ADDR_BASE`, 1024: byte address mapped to SRAM half-word 0; subtracted from every request address.
- `SRAM_AW`, 18: SRAM half-word address width.
- `HOLD_CYCLES`, 1: clock cycles each half-word phase is held on the SRAM pins; legal range 1..15.
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `rd_en`, in, 1: word read request from the EX/MEM register.
- `wr_en`, in, 1: word write request from the EX/MEM register.
- `address`, in, 32: byte address (ALU result).
- `write_data`, in, 32: store value.
- `read_data`, out, 32: last completed read word.
- `ready`, out, 1: high means the pipeline may advance; low freezes all pipeline registers.
- `sram_addr`, out, SRAM_AW: SRAM half-word address.
- `sram_dq_out`, out, 16: write data to the SRAM.
- `sram_dq_in`, in, 16: read data from the SRAM.
- `sram_dq_oe`, out, 1: drive enable for `sram_dq_out`.
- `sram_we_n`, out, 1: active-low write strobe.

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE: no SRAM activity. If `rd_en|wr_en` is sampled high, latch the op (`wr_en` wins if both are high), latch `offset = address - ADDR_BASE` (32-bit, modulo 2^32, no range check), latch `write_data`, clear the hold counter, and go to LO.
- LO:
  - `sram_addr = {offset[SRAM_AW:2], 1'b0}`.
  - Write: `sram_dq_oe=1`, `sram_dq_out=wdata[15:0]`, `sram_we_n=0`.
  - Read: `oe=0`, `we_n=1`.
  - The hold counter increments each cycle. On the last cycle (counter = HOLD_CYCLES-1): a read captures `sram_dq_in` into `read_data[15:0]`; clear the counter and go to HI.
- HI: identical to LO, with address LSB 1 and data bits [31:16]. On its last cycle go to DONE.
- DONE: `we_n=1`, `oe=0`. Go to IDLE unconditionally.
- `ready` is combinational: `(state==IDLE && !(rd_en|wr_en)) || state==DONE`.
- `offset[1:0]` is ignored; misaligned addresses access the containing word.
- `read_data` holds its value across writes and idle cycles. Both halves update only by read capture.

## Timing
- Reset values: state IDLE, `read_data=0`, `sram_addr=0`, `sram_dq_out=0`, `sram_dq_oe=0`, `sram_we_n=1`, counter 0. `ready` is therefore 1 when no request is pending.
- With request first seen in cycle 0 and H = HOLD_CYCLES:
  - LO occupies cycles 1..H.
  - HI occupies cycles H+1..2H.
  - DONE is cycle 2H+1, with `ready=1` and `read_data` valid.
  - Total 2H+2 cycles, i.e. 4 cycles at H=1.
- `ready` is 0 in cycles 0..2H. The pipeline advances on the edge that ends DONE.
- A request still present in the cycle after DONE belongs to the next instruction and starts a new transaction from IDLE with no bubble.
- A request deasserting during LO/HI (pipeline is frozen, so this is illegal) is ignored; the latched transaction completes.
- `rst_n` low mid-transaction aborts immediately to the reset values. The SRAM write strobe releases asynchronously; a partially written word is accepted.
- SRAM outputs are registered: no combinational path from request inputs to SRAM pins.

## Structure
- Shared package `sram_ctrl_pkg`:
  - state enum `sram_state_t` {IDLE, LO, HI, DONE};
  - constants `SRAM_DW=16`, default `ADDR_BASE=1024`.
- No sub-module is needed in RTL. The bench uses a behavioural `sram_model` (asynchronous read, write on `we_n` low), kept in the verification tree.

## Test plan
- Reset release with no request: `ready=1`, `sram_we_n=1`, `sram_dq_oe=0`, `read_data=0`.
- Write `address=1028`, `write_data=0xDEADBEEF`, H=1:
  - SRAM half-word 2 gets 0xBEEF in cycle 1;
  - half-word 3 gets 0xDEAD in cycle 2;
  - `ready` is 0,0,0,1 over cycles 0..3.
- Read back `address=1028`: `read_data=0xDEADBEEF` in cycle 3 with `ready=1`. Repeat with H=3: `ready` rises in cycle 7.
- `rd_en` and `wr_en` both high at `address=1024`, `write_data=0x12345678`: a write is performed, and `read_data` is unchanged.
- Back-to-back requests (a read held through DONE, then a new read at 1032): second transaction starts in the cycle after DONE, with no extra idle cycle.
- `rst_n` pulsed low in cycle 2 of a write: outputs return to reset values immediately, and the state is IDLE on release.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// Sequences 32-bit accesses as two 16-bit SRAM phases.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    localparam int SRAM_DW           = 16;
    localparam int DEFAULT_ADDR_BASE = 1024;

endpackage

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller: splits each 32-bit word access into two half-word
// cycles on a 16-bit asynchronous SRAM and stalls the pipeline until done.
module sram_mem_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam logic [3:0] LAST_CNT = 4'(HOLD_CYCLES - 1);
    localparam int         WA_W     = SRAM_AW - 1;

    sram_state_t        state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               isWrite_q, isWrite_d;
    logic [WA_W-1:0]    wordAddr_q, wordAddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        readData_q, readData_d;
    logic [SRAM_AW-1:0] sramAddr_q, sramAddr_d;
    logic [SRAM_DW-1:0] dqOut_q, dqOut_d;
    logic               dqOe_q, dqOe_d;
    logic               weN_q, weN_d;

    logic [31:0] reqOffset;
    logic        unusedOffsetBits;
    logic        request;

    assign request          = rd_en | wr_en;
    assign reqOffset        = address - ADDR_BASE;
    assign unusedOffsetBits = ^{reqOffset[31:SRAM_AW+1], reqOffset[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            isWrite_q  <= 1'b0;
            wordAddr_q <= '0;
            wdata_q    <= '0;
            readData_q <= '0;
            sramAddr_q <= '0;
            dqOut_q    <= '0;
            dqOe_q     <= 1'b0;
            weN_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            isWrite_q  <= isWrite_d;
            wordAddr_q <= wordAddr_d;
            wdata_q    <= wdata_d;
            readData_q <= readData_d;
            sramAddr_q <= sramAddr_d;
            dqOut_q    <= dqOut_d;
            dqOe_q     <= dqOe_d;
            weN_q      <= weN_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        isWrite_d  = isWrite_q;
        wordAddr_d = wordAddr_q;
        wdata_d    = wdata_q;
        readData_d = readData_q;
        sramAddr_d = sramAddr_q;
        dqOut_d    = dqOut_q;
        dqOe_d     = 1'b0;
        weN_d      = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (request) begin
                    isWrite_d  = wr_en;
                    wordAddr_d = reqOffset[SRAM_AW:2];
                    wdata_d    = write_data;
                    cnt_d      = '0;
                    state_d    = LO;
                end
            end
            LO: begin
                if (cnt_q == LAST_CNT) begin
                    if (!isWrite_q) readData_d[15:0] = sram_dq_in;
                    cnt_d   = '0;
                    state_d = HI;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HI: begin
                if (cnt_q == LAST_CNT) begin
                    if (!isWrite_q) readData_d[31:16] = sram_dq_in;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pins are registered from the upcoming state so they are valid
        // for the whole of each LO/HI cycle.
        unique case (state_d)
            LO: begin
                sramAddr_d = {wordAddr_d, 1'b0};
                dqOe_d     = isWrite_d;
                weN_d      = !isWrite_d;
                if (isWrite_d) dqOut_d = wdata_d[15:0];
            end
            HI: begin
                sramAddr_d = {wordAddr_d, 1'b1};
                dqOe_d     = isWrite_d;
                weN_d      = !isWrite_d;
                if (isWrite_d) dqOut_d = wdata_d[31:16];
            end
            default: begin
                dqOe_d = 1'b0;
                weN_d  = 1'b1;
            end
        endcase
    end

    assign ready       = (state_q == IDLE && !request) || (state_q == DONE);
    assign read_data   = readData_q;
    assign sram_addr   = sramAddr_q;
    assign sram_dq_out = dqOut_q;
    assign sram_dq_oe  = dqOe_q;
    assign sram_we_n   = weN_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl: two instances (hold 1 and hold 3), each
// attached to a behavioural SRAM array with asynchronous read.
module tb_sram_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        preloadEn;

    logic        rdEn1, wrEn1, ready1, dqOe1, weN1;
    logic [31:0] address1, writeData1, readData1;
    logic [17:0] sramAddr1;
    logic [15:0] dqOut1, dqIn1;

    logic        rdEn3, wrEn3, ready3, dqOe3, weN3;
    logic [31:0] address3, writeData3, readData3;
    logic [17:0] sramAddr3;
    logic [15:0] dqOut3, dqIn3;

    logic [15:0] mem1 [0:(1<<18)-1];
    logic [15:0] mem3 [0:(1<<18)-1];

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    sram_mem_ctrl #(.ADDR_BASE(1024), .SRAM_AW(18), .HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rd_en(rdEn1), .wr_en(wrEn1),
        .address(address1), .write_data(writeData1), .read_data(readData1),
        .ready(ready1), .sram_addr(sramAddr1), .sram_dq_out(dqOut1),
        .sram_dq_in(dqIn1), .sram_dq_oe(dqOe1), .sram_we_n(weN1)
    );

    sram_mem_ctrl #(.ADDR_BASE(1024), .SRAM_AW(18), .HOLD_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .rd_en(rdEn3), .wr_en(wrEn3),
        .address(address3), .write_data(writeData3), .read_data(readData3),
        .ready(ready3), .sram_addr(sramAddr3), .sram_dq_out(dqOut3),
        .sram_dq_in(dqIn3), .sram_dq_oe(dqOe3), .sram_we_n(weN3)
    );

    // Behavioural SRAM: combinational read, write while we_n is low.
    assign dqIn1 = mem1[sramAddr1];
    assign dqIn3 = mem3[sramAddr3];

    always @(posedge clk) begin
        if (preloadEn) begin
            mem1[4] <= 16'h1111;
            mem1[5] <= 16'h2222;
            mem3[2] <= 16'hCAFE;
            mem3[3] <= 16'hF00D;
        end
        if (!weN1) mem1[sramAddr1] <= dqOut1;
        if (!weN3) mem3[sramAddr3] <= dqOut3;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data);
        rdEn1      = rd;
        wrEn1      = wr;
        address1   = addr;
        writeData1 = data;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        preloadEn = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        rdEn3 = 1'b0; wrEn3 = 1'b0; address3 = '0; writeData3 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        preloadEn = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(ready1), 32'd1);
        checkOutput("rst_we_n", 32'(weN1), 32'd1);
        checkOutput("rst_oe", 32'(dqOe1), 32'd0);
        checkOutput("rst_rdata", readData1, 32'd0);
        checkOutput("rst_addr", 32'(sramAddr1), 32'd0);

        // Write 0xDEADBEEF at 1028 -> half-words 2 and 3
        nextCycle(); applyStimulus(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF); #1;
        checkOutput("wr_c0_ready", 32'(ready1), 32'd0);
        nextCycle(); #1;
        checkOutput("wr_c1_ready", 32'(ready1), 32'd0);
        checkOutput("wr_c1_addr", 32'(sramAddr1), 32'd2);
        checkOutput("wr_c1_dq", 32'(dqOut1), 32'h0000BEEF);
        checkOutput("wr_c1_we_n", 32'(weN1), 32'd0);
        checkOutput("wr_c1_oe", 32'(dqOe1), 32'd1);
        nextCycle(); #1;
        checkOutput("wr_c2_ready", 32'(ready1), 32'd0);
        checkOutput("wr_c2_addr", 32'(sramAddr1), 32'd3);
        checkOutput("wr_c2_dq", 32'(dqOut1), 32'h0000DEAD);
        checkOutput("wr_c2_we_n", 32'(weN1), 32'd0);
        nextCycle(); #1;
        checkOutput("wr_c3_ready", 32'(ready1), 32'd1);
        checkOutput("wr_c3_we_n", 32'(weN1), 32'd1);
        checkOutput("wr_c3_oe", 32'(dqOe1), 32'd0);
        nextCycle(); applyStimulus(1'b0, 1'b0, 32'd0, 32'd0); #1;
        checkOutput("wr_mem2", 32'(mem1[2]), 32'h0000BEEF);
        checkOutput("wr_mem3", 32'(mem1[3]), 32'h0000DEAD);
        checkOutput("wr_idle_ready", 32'(ready1), 32'd1);

        // Read back 1028
        nextCycle(); applyStimulus(1'b1, 1'b0, 32'd1028, 32'd0); #1;
        checkOutput("rd_c0_ready", 32'(ready1), 32'd0);
        nextCycle(); #1;
        checkOutput("rd_c1_ready", 32'(ready1), 32'd0);
        checkOutput("rd_c1_we_n", 32'(weN1), 32'd1);
        checkOutput("rd_c1_oe", 32'(dqOe1), 32'd0);
        nextCycle(); #1;
        checkOutput("rd_c2_ready", 32'(ready1), 32'd0);
        nextCycle(); #1;
        checkOutput("rd_c3_ready", 32'(ready1), 32'd1);
        checkOutput("rd_c3_rdata", readData1, 32'hDEADBEEF);
        nextCycle(); applyStimulus(1'b0, 1'b0, 32'd0, 32'd0); #1;

        // rd_en and wr_en together: write wins, read_data untouched
        nextCycle(); applyStimulus(1'b1, 1'b1, 32'd1024, 32'h12345678); #1;
        nextCycle(); #1;
        checkOutput("both_c1_we_n", 32'(weN1), 32'd0);
        checkOutput("both_c1_addr", 32'(sramAddr1), 32'd0);
        nextCycle(); #1;
        nextCycle(); #1;
        checkOutput("both_c3_ready", 32'(ready1), 32'd1);
        checkOutput("both_c3_rdata", readData1, 32'hDEADBEEF);
        nextCycle(); applyStimulus(1'b0, 1'b0, 32'd0, 32'd0); #1;
        checkOutput("both_mem0", 32'(mem1[0]), 32'h00005678);
        checkOutput("both_mem1", 32'(mem1[1]), 32'h00001234);

        // Back-to-back: read 1024 held through DONE, then read 1032
        nextCycle(); applyStimulus(1'b1, 1'b0, 32'd1024, 32'd0); #1;
        nextCycle(); #1;
        nextCycle(); #1;
        nextCycle(); #1;
        checkOutput("b2b_c3_ready", 32'(ready1), 32'd1);
        checkOutput("b2b_c3_rdata", readData1, 32'h12345678);
        nextCycle(); applyStimulus(1'b1, 1'b0, 32'd1032, 32'd0); #1;
        checkOutput("b2b_c4_ready", 32'(ready1), 32'd0);
        nextCycle(); #1;
        checkOutput("b2b_c5_addr", 32'(sramAddr1), 32'd4);
        checkOutput("b2b_c5_ready", 32'(ready1), 32'd0);
        nextCycle(); #1;
        nextCycle(); #1;
        checkOutput("b2b_c7_ready", 32'(ready1), 32'd1);
        checkOutput("b2b_c7_rdata", readData1, 32'h22221111);
        nextCycle(); applyStimulus(1'b0, 1'b0, 32'd0, 32'd0); #1;

        // Hold of 3 cycles: ready rises in cycle 7
        nextCycle();
        rdEn3 = 1'b1; address3 = 32'd1028;
        #1;
        checkOutput("h3_c0_ready", 32'(ready3), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            nextCycle(); #1;
            checkOutput($sformatf("h3_c%0d_ready", i), 32'(ready3), (i == 7) ? 32'd1 : 32'd0);
        end
        checkOutput("h3_rdata", readData3, 32'hF00DCAFE);
        nextCycle(); rdEn3 = 1'b0; #1;

        // Reset asserted in cycle 2 of a write to 1032
        nextCycle(); applyStimulus(1'b0, 1'b1, 32'd1032, 32'h0BADF00D); #1;
        nextCycle(); #1;
        nextCycle(); #1;
        checkOutput("rst_mid_pre_we_n", 32'(weN1), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_we_n", 32'(weN1), 32'd1);
        checkOutput("rst_mid_oe", 32'(dqOe1), 32'd0);
        checkOutput("rst_mid_addr", 32'(sramAddr1), 32'd0);
        checkOutput("rst_mid_dq", 32'(dqOut1), 32'd0);
        checkOutput("rst_mid_rdata", readData1, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        checkOutput("rst_mid_ready", 32'(ready1), 32'd1);
        nextCycle();
        rst_n = 1'b1;
        nextCycle(); #1;
        checkOutput("rst_rel_ready", 32'(ready1), 32'd1);
        checkOutput("rst_rel_we_n", 32'(weN1), 32'd1);
        checkOutput("rst_partial_mem4", 32'(mem1[4]), 32'h0000F00D);
        applyStimulus(1'b1, 1'b0, 32'd1024, 32'd0);
        #1;
        checkOutput("rst_rel_idle_req", 32'(ready1), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
